// File: rtl/pyr_stream_pkg.sv
// Shared types and constants for the pyramid-stream frame sink.
// CRC helper is used only when PYR_SINK_CRC_EN is defined.
package pyr_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } sink_state_e;

  localparam int ERR_LINE  = 0;
  localparam int ERR_FRAME = 1;
  localparam int ERR_OVF   = 2;

  localparam logic [15:0] CRC_POLY = 16'h1021;

  // One MSB-first CRC-16/CCITT bit step.
  function automatic logic [15:0] crc16_bit(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    crc16_bit = {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/pyr_sink_addr_gen.sv
// Column/row/linear-address counters for the frame sink.
// Counters describe the position of the next expected pixel.
module pyr_sink_addr_gen #(
  parameter int IMG_W  = 512,
  parameter int IMG_H  = 384,
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              col_zero,
  output logic              at_last,
  output logic              past_end
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0]  col, cur_col, col_nxt;
  logic [ROW_W-1:0]  row, cur_row, row_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic              cur_past, cur_last, past_nxt;

  // A start beat is the pixel at (0,0) of the selected buffer.
  always_comb begin
    cur_col  = start ? '0 : col;
    cur_row  = start ? '0 : row;
    wr_addr  = start ? base : addr;
    cur_past = start ? 1'b0 : past_end;
    cur_last = (cur_col == COL_LAST) && (cur_row == ROW_LAST);
    col_nxt  = cur_col + 1'b1;
    row_nxt  = cur_row;
    if (cur_col == COL_LAST) begin
      col_nxt = '0;
      row_nxt = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
    end
    addr_nxt = wr_addr + 1'b1;
    past_nxt = cur_past | cur_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col      <= '0;
      row      <= '0;
      addr     <= '0;
      past_end <= 1'b0;
    end else if (start || step) begin
      col      <= col_nxt;
      row      <= row_nxt;
      addr     <= addr_nxt;
      past_end <= past_nxt;
    end
  end

  assign col_zero = (col == '0);
  assign at_last  = (col == COL_LAST) && (row == ROW_LAST);

endmodule

// File: rtl/pyr_frame_sink.sv
// Pyramid-stream frame sink: framing checks, ping-pong buffer writes, frame handoff.
// Define PYR_SINK_CRC_EN to add the per-frame CRC-16 output frame_crc.
module pyr_frame_sink
  import pyr_stream_pkg::*;
#(
  parameter int IMG_W       = 512,
  parameter int IMG_H       = 384,
  parameter int PIXEL_WIDTH = 8,
  parameter int ADDR_W      = 18,
  parameter int BUF1_BASE   = 196608
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PIXEL_WIDTH-1:0] in_data,
  input  logic                   in_vld,
  input  logic                   in_sof,
  input  logic                   in_sol,
  input  logic                   in_eof,
  output logic                   mem_we,
  output logic [ADDR_W:0]        mem_addr,
  output logic [PIXEL_WIDTH-1:0] mem_wdata,
  output logic [1:0]             buf_full,
  input  logic [1:0]             buf_release,
  output logic                   frame_done,
  output logic                   done_buf,
  output logic                   frame_err,
  output logic [2:0]             err_code,
  input  logic                   err_clr,
  output logic [15:0]            frame_cnt,
`ifdef PYR_SINK_CRC_EN
  output logic [15:0]            frame_crc,
`endif
  output logic [1:0]             state_dbg
);

  // The input stream is valid-only: there is no ready, so every in_vld beat
  // is consumed in the cycle it is presented; sof/sol/eof mean nothing without in_vld.

  sink_state_e       state, state_nxt;
  logic              wr_buf, wr_buf_nxt, wr_buf_eff;
  logic              done_pend, done_nxt;
  logic [1:0]        full_eff, full_set;
  logic              adm_ok, adm_buf, admit;
  logic              start, step, we_nxt, we_buf;
  logic [ADDR_W-1:0] base_sel, gen_addr;
  logic              col_zero, at_last, past_end;
  logic              line_bad, frame_bad, err_pulse;
  logic [2:0]        err_set;

  pyr_sink_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .step    (step),
    .base    (base_sel),
    .wr_addr (gen_addr),
    .col_zero(col_zero),
    .at_last (at_last),
    .past_end(past_end)
  );

  // A completion still pending this cycle already counts as full/toggled,
  // so a sof right behind a good eof sees the correct buffer state.
  always_comb begin
    wr_buf_eff = wr_buf ^ done_pend;
    full_set   = done_pend ? (2'b01 << wr_buf) : 2'b00;
    full_eff   = buf_full | full_set;
    adm_buf    = wr_buf_eff;
    adm_ok     = 1'b1;
    if (full_eff[wr_buf_eff]) begin
      adm_buf = ~wr_buf_eff;
      adm_ok  = !full_eff[~wr_buf_eff];
    end
    base_sel  = adm_buf ? ADDR_W'(BUF1_BASE) : '0;
    line_bad  = (in_sol && !col_zero) || (!in_sol && col_zero);
    frame_bad = (in_eof && !at_last) || past_end;
  end

  always_comb begin
    state_nxt  = state;
    wr_buf_nxt = wr_buf_eff;
    done_nxt   = 1'b0;
    admit      = 1'b0;
    start      = 1'b0;
    step       = 1'b0;
    we_nxt     = 1'b0;
    err_set    = 3'b000;
    err_pulse  = 1'b0;
    case (state)
      IDLE, DROP: begin
        if (in_vld && in_sof) admit = 1'b1;
        else if (state == DROP && in_vld && in_eof) state_nxt = IDLE;
      end
      RECV: begin
        if (in_vld) begin
          if (in_sof) begin
            err_set[ERR_FRAME] = 1'b1;
            err_pulse          = 1'b1;
            admit              = 1'b1;
          end else if (line_bad || frame_bad) begin
            err_set[ERR_LINE]  = line_bad;
            err_set[ERR_FRAME] = frame_bad;
            err_pulse          = 1'b1;
            state_nxt          = in_eof ? IDLE : DROP;
          end else begin
            step   = 1'b1;
            we_nxt = 1'b1;
            if (in_eof) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (admit) begin
      if (adm_ok) begin
        start      = 1'b1;
        we_nxt     = 1'b1;
        wr_buf_nxt = adm_buf;
        state_nxt  = RECV;
      end else begin
        err_set[ERR_OVF] = 1'b1;
        err_pulse        = 1'b1;
        state_nxt        = in_eof ? IDLE : DROP;
      end
    end
    we_buf = start ? adm_buf : wr_buf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_buf     <= 1'b0;
      done_pend  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      buf_full   <= 2'b00;
      frame_done <= 1'b0;
      done_buf   <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= 3'b000;
      frame_cnt  <= 16'd0;
    end else begin
      state      <= state_nxt;
      wr_buf     <= wr_buf_nxt;
      done_pend  <= done_nxt;
      mem_we     <= we_nxt;
      if (we_nxt) begin
        mem_addr  <= {we_buf, gen_addr};
        mem_wdata <= in_data;
      end
      // Set beats release for the same bit.
      buf_full   <= (buf_full & ~buf_release) | full_set;
      frame_done <= done_pend;
      if (done_pend) begin
        done_buf  <= wr_buf;
        frame_cnt <= frame_cnt + 16'd1;
      end
      frame_err  <= err_pulse;
      err_code   <= (err_clr ? 3'b000 : err_code) | err_set;
    end
  end

`ifdef PYR_SINK_CRC_EN
  logic [15:0] crc_acc, crc_calc;

  always_comb begin
    crc_calc = start ? 16'hFFFF : crc_acc;
    for (int i = PIXEL_WIDTH - 1; i >= 0; i--) begin
      crc_calc = crc16_bit(crc_calc, in_data[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_acc   <= 16'hFFFF;
      frame_crc <= 16'hFFFF;
    end else begin
      if (start || step) crc_acc <= crc_calc;
      if (done_pend) frame_crc <= crc_acc;
    end
  end
`endif

  assign state_dbg = state;

endmodule
